// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Time-multiplexed scan controller for a three-digit 7-segment display showing
// a UART byte (two hex digits) and a mode letter. Each digit is lit for
// REFRESH_DIV cycles, separated by BLANK_CYCLES cycles with every digit dark.
// The displayed values (Rx_Data, Tx_Data, Mode) only change on the final
// blank cycle, so a lit digit never shows a half-updated value.
//
// Parameters:
//   REFRESH_DIV  - cycles each digit is lit (>= 2)
//   BLANK_CYCLES - dark cycles between digits (>= 1)
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   rx_valid   in   one-cycle strobe: rx_byte holds a new received byte
//   rx_byte    in   [7:0] received byte
//   tx_byte    in   [7:0] byte about to be transmitted
//   mode_in    in   asynchronous mode switch (0 = receive, 1 = transmit)
//   Array      out  [1:0] digit select (0 upper hex, 1 lower hex, 2 mode, 3 dark)
//   Mode       out  synchronized mode, updated only while dark
//   Rx_Data    out  [7:0] displayed received byte
//   Tx_Data    out  [7:0] displayed transmit byte
//   rx_seen    out  sticky flag, set by the first rx_valid after reset
//   state_dbg  out  current scan FSM state (0 = BLANK, 1 = SHOW)
//
// Handshake: rx_valid is a strobe with no ready; a byte is accepted on every
// cycle rx_valid = 1, and the most recent one is the one displayed.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    input  logic [7:0] tx_byte,
    input  logic       mode_in,
    output logic [1:0] Array,
    output logic       Mode,
    output logic [7:0] Rx_Data,
    output logic [7:0] Tx_Data,
    output logic       rx_seen,
    output logic       state_dbg
);

    // One counter serves both states, so it must reach the larger terminal.
    localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_q, digit_d;
    logic [1:0]    sync_q;
    logic [7:0]    shadow_q;
    logic          mode_s;
    logic          blank_last;
    logic          show_last;

    assign mode_s     = sync_q[1];
    assign blank_last = (state_q == BLANK) && (cnt_q == BLANK_LAST);
    assign show_last  = (state_q == SHOW)  && (cnt_q == SHOW_LAST);

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        digit_d = digit_q;
        case (state_q)
            BLANK: begin
                if (blank_last) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    // A mode change restarts the scan at the first digit so
                    // the new mode is read from the top.
                    if (mode_s != Mode) begin
                        digit_d = 2'd0;
                    end
                end
            end
            SHOW: begin
                if (show_last) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    digit_d = (digit_q == 2'd2) ? 2'd0 : digit_q + 2'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            digit_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    // Mode synchronizer, receive shadow and display registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q   <= 2'b00;
            shadow_q <= 8'h00;
            rx_seen  <= 1'b0;
            Rx_Data  <= 8'h00;
            Tx_Data  <= 8'h00;
            Mode     <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], mode_in};
            if (rx_valid) begin
                shadow_q <= rx_byte;
                rx_seen  <= 1'b1;
            end
            if (blank_last) begin
                // Bypass the shadow when a byte arrives on the update cycle.
                Rx_Data <= rx_valid ? rx_byte : shadow_q;
                Tx_Data <= tx_byte;
                Mode    <= mode_s;
            end
        end
    end

    assign Array     = (state_q == SHOW) ? digit_q : 2'd3;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Directed bench for display_scan_ctrl with REFRESH_DIV = 4, BLANK_CYCLES = 2.
// Inputs change 1 time unit after a rising edge; outputs are observed at the
// same point. The variable t counts rising edges since reset was released, so
// the expected digit select at observation t is scan_pat[t % 18].
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       mode_in;
    logic [1:0] Array;
    logic       Mode;
    logic [7:0] Rx_Data;
    logic [7:0] Tx_Data;
    logic       rx_seen;
    logic       state_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;

    // One full scan period, hand-derived: 2 dark + 4 lit per digit.
    logic [1:0] scan_pat [0:17] = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0,
                                    2'd3, 2'd3, 2'd1, 2'd1, 2'd1, 2'd1,
                                    2'd3, 2'd3, 2'd2, 2'd2, 2'd2, 2'd2};

    display_scan_ctrl #(
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .tx_byte   (tx_byte),
        .mode_in   (mode_in),
        .Array     (Array),
        .Mode      (Mode),
        .Rx_Data   (Rx_Data),
        .Tx_Data   (Tx_Data),
        .rx_seen   (rx_seen),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic run_to(input int target);
        while (t < target) tick();
    endtask

    task automatic check_scan(input string tag);
        for (int i = 0; i < 20; i++) begin
            chk(tag, {6'b0, Array}, {6'b0, scan_pat[t % 18]});
            if (i < 19) tick();
        end
        tick();
    endtask

    initial begin
        // Reset block
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        tx_byte  = 8'h00;
        mode_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_array",   {6'b0, Array}, 8'h03);
        chk("rst_mode",    {7'b0, Mode},  8'h00);
        chk("rst_rx_data", Rx_Data,       8'h00);
        chk("rst_tx_data", Tx_Data,       8'h00);
        chk("rst_rx_seen", {7'b0, rx_seen}, 8'h00);
        chk("rst_state",   {7'b0, state_dbg}, 8'h00);

        // Scan order after release
        reset = 1'b0;
        t     = 0;
        check_scan("scan");
        chk("scan_rx_seen", {7'b0, rx_seen}, 8'h00);

        // Byte arriving during a lit digit is held back until the blank end
        chk("t20_digit0", {6'b0, Array}, 8'h00);
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        tick();
        rx_valid = 1'b0;
        chk("seen_after_strobe", {7'b0, rx_seen}, 8'h01);
        chk("rx_held_show",      Rx_Data,         8'h00);
        run_to(25);
        chk("rx_held_blank_last", Rx_Data,        8'h00);
        chk("t25_dark",          {6'b0, Array},   8'h03);
        tick();
        chk("rx_updated",        Rx_Data,         8'hA5);
        chk("t26_digit1",        {6'b0, Array},   8'h01);

        // Shadow 0x11, then a new byte on the last blank cycle wins
        rx_valid = 1'b1;
        rx_byte  = 8'h11;
        tick();
        rx_valid = 1'b0;
        run_to(31);
        chk("rx_before_bypass",  Rx_Data,         8'hA5);
        chk("t31_dark",          {6'b0, Array},   8'h03);
        rx_valid = 1'b1;
        rx_byte  = 8'h3C;
        tick();
        rx_valid = 1'b0;
        chk("rx_bypass",         Rx_Data,         8'h3C);
        chk("t32_digit2",        {6'b0, Array},   8'h02);

        // Mode change during digit 1 restarts the scan at digit 0
        run_to(44);
        chk("t44_digit1",        {6'b0, Array},   8'h01);
        mode_in = 1'b1;
        tx_byte = 8'h5A;
        run_to(49);
        chk("mode_held",         {7'b0, Mode},    8'h00);
        chk("tx_held",           Tx_Data,         8'h00);
        chk("t49_dark",          {6'b0, Array},   8'h03);
        tick();
        chk("mode_updated",      {7'b0, Mode},    8'h01);
        chk("tx_updated",        Tx_Data,         8'h5A);
        chk("mode_forces_digit0", {6'b0, Array},  8'h00);
        chk("state_show",        {7'b0, state_dbg}, 8'h01);
        run_to(56);
        chk("t56_digit1",        {6'b0, Array},   8'h01);
        chk("mode_stable",       {7'b0, Mode},    8'h01);

        // Load 0xA5 again, then reset in the middle of digit 2
        rx_valid = 1'b1;
        rx_byte  = 8'hA5;
        tick();
        rx_valid = 1'b0;
        run_to(63);
        chk("t63_digit2",        {6'b0, Array},   8'h02);
        chk("rx_before_reset",   Rx_Data,         8'hA5);
        reset   = 1'b1;
        mode_in = 1'b0;
        #1;
        chk("async_rst_array",   {6'b0, Array},   8'h03);
        chk("async_rst_rx_data", Rx_Data,         8'h00);
        chk("async_rst_rx_seen", {7'b0, rx_seen}, 8'h00);
        chk("async_rst_mode",    {7'b0, Mode},    8'h00);
        chk("async_rst_tx_data", Tx_Data,         8'h00);
        tick();
        tick();
        chk("rst_held_array",    {6'b0, Array},   8'h03);

        // Sequence restarts identically after release
        reset = 1'b0;
        t     = 0;
        check_scan("rescan");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning the number of clk cycles each digit is lit (must be >= 2).
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000, meaning the number of clk cycles all digits are dark between digits (must be >= 1).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port rx_valid, input, 1 bit: one-cycle strobe, rx_byte holds a newly received byte.
REQ-007 SHALL have port rx_byte, input, 8 bits: received byte from the UART receiver.
REQ-008 SHALL have port tx_byte, input, 8 bits: next byte to be sent, from the switches/transmit path.
REQ-009 SHALL have port mode_in, input, 1 bit: asynchronous mode switch (0 = receive, 1 = transmit).
REQ-010 SHALL have port Array, output, 2 bits: digit select to the 7-segment decoder (0 = upper hex, 1 = lower hex, 2 = mode letter, 3 = all dark).
REQ-011 SHALL have port Mode, output, 1 bit: synchronized, tear-free mode to the decoder.
REQ-012 SHALL have port Rx_Data, output, 8 bits: displayed received byte.
REQ-013 SHALL have port Tx_Data, output, 8 bits: displayed transmit byte.
REQ-014 SHALL have port rx_seen, output, 1 bit: high from the first rx_valid after reset onward.

Function
REQ-015 SHALL run a 2-state FSM: BLANK (Array = 3) and SHOW (Array = digit index).
REQ-016 SHALL stay in BLANK for exactly BLANK_CYCLES cycles, then enter SHOW with the current digit index.
REQ-017 SHALL stay in SHOW for exactly REFRESH_DIV cycles, then enter BLANK and advance the digit index 0->1->2->0; index 3 is never shown.
REQ-018 SHALL use one shared cycle counter, cleared on every state transition and wide enough for max(REFRESH_DIV, BLANK_CYCLES).
REQ-019 SHALL pass mode_in through a 2-flop synchronizer; the synchronized value is mode_s.
REQ-020 SHALL capture rx_byte into a shadow register on every cycle where rx_valid = 1; back-to-back strobes are allowed, and the last one wins.
REQ-021 SHALL update Rx_Data, Tx_Data and Mode only on the last cycle of BLANK, so that no value changes while a digit is lit.
REQ-022 At that update, Rx_Data SHALL take the shadow register; if rx_valid = 1 in the same cycle, Rx_Data SHALL take rx_byte directly (bypass).
REQ-023 At that update, Tx_Data SHALL take tx_byte and Mode SHALL take mode_s.
REQ-024 If the Mode value loaded differs from the previous Mode, the digit index SHALL be forced to 0 for the following SHOW.
REQ-025 SHALL hold rx_seen sticky at 1 once set; only reset clears it.

Reset
REQ-026 While reset = 1, the block SHALL force: state BLANK, counter 0, digit index 0, Array = 3, Mode = 0, Rx_Data = 0x00, Tx_Data = 0x00, shadow 0x00, rx_seen = 0, synchronizer flops 0.
REQ-027 Reset asserted mid-SHOW or mid-BLANK SHALL take effect immediately and asynchronously, with no partial update of the outputs.
REQ-028 After reset deasserts, the first SHOW SHALL be digit 0, after BLANK_CYCLES cycles.

Verification (REFRESH_DIV = 4, BLANK_CYCLES = 2)
REQ-029 Scan order: release reset, hold inputs -> Array = 3,3,0,0,0,0,3,3,1,1,1,1,3,3,2,2,2,2,3,3,0,..., giving an 18-cycle period.
REQ-030 Tear-free update: rx_valid with rx_byte = 0xA5 during a SHOW of digit 0 -> Rx_Data stays 0x00 until the last BLANK cycle, then becomes 0xA5; rx_seen = 1 from the cycle after the strobe.
REQ-031 Simultaneous events: shadow = 0x11, and rx_valid with rx_byte = 0x3C on the last BLANK cycle -> Rx_Data = 0x3C, not 0x11.
REQ-032 Mode change: toggle mode_in 0->1 during a SHOW of digit 1 -> Mode changes at the next BLANK end, the next SHOW is digit 0, and Tx_Data = tx_byte.
REQ-033 Reset mid-operation: assert reset during a SHOW of digit 2 with Rx_Data = 0xA5 -> Array = 3, Rx_Data = 0x00 and rx_seen = 0 in the same cycle; after release the sequence restarts as in REQ-029.
